load_store_unit: RTL
====================

# load_store_unit

Sits between the single-cycle datapath and the word-wide data memory, which writes whole 32-bit words on the falling clock edge and reads combinationally. Converts MIPS byte, halfword and word loads and stores into word accesses. Sub-word loads are a one-cycle extract-and-extend. Sub-word stores use a two-cycle read-modify-write sequence that stalls the core for one cycle.

## Interface
- `BADDR_W`, default 15: byte-address width; word address is `BADDR_W-2` bits (13).
- `clock` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in 1: access request this cycle.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 0 = byte, 1 = half, 2 = word; 3 is treated as word.
- `req_unsigned` in 1: zero-extend sub-word loads (lbu/lhu).
- `req_addr` in `BADDR_W`: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `stall` out 1: core must hold PC and all `req_*` inputs stable.
- `rdata` out 32: load result, combinational.
- `misaligned` out 1: misalignment pulse; present only with the macro.
- `mem_addr` out `BADDR_W-2`: word address, equal to `req_addr[BADDR_W-1:2]`.
- `mem_read` out 1: memory read enable.
- `mem_write` out 1: memory write enable; sampled by memory on the falling edge.
- `mem_wdata` out 32: word to write.
- `mem_rdata` in 32: memory read data, combinational.

## Operation
- Endianness is big-endian: byte offset 0 is `[31:24]`, offset 3 is `[7:0]`; half offset 0 is `[31:16]`.
- **Load, any size:** `mem_read`=1 in the same cycle; `rdata` = selected lane sign- or zero-extended; no stall.
- **Word store:** `mem_write`=1 and `mem_wdata`=`req_wdata` in the same cycle; no stall.
- **Sub-word store FSM**, state `IDLE`:
  - On `req_valid & req_write & size!=word`: `mem_read`=1, `stall`=1.
  - At the rising edge, capture `mem_rdata` into `merge_q`, then go to `RMW_WR`.
- **State `RMW_WR`:**
  - `mem_wdata` = `merge_q` with the target lane replaced by `req_wdata[7:0]` or `[15:0]`.
  - `mem_write`=1, `stall`=0, then return to `IDLE` at the next edge.
- **Abort:** if `req_valid`=0 in `RMW_WR`, no write is issued; return to `IDLE`.
- **Idle:** `req_valid`=0 in `IDLE` gives `mem_read`=`mem_write`=0 and `rdata`=0.
- **Alignment, macro absent:** low byte-address bits are ignored.
  - Half uses offset `{addr[1],0}`.
  - Word ignores `addr[1:0]`.
- **Reset mid-sequence:** state returns to `IDLE` and `merge_q` is cleared; the pending write is lost, with no `mem_write` pulse.

## Timing
- **Reset values:** state=`IDLE`, `merge_q`=0, `stall`=0, `mem_read`=0, `mem_write`=0, `rdata`=0, `misaligned`=0.
- **Latency:**
  - Loads and word stores: 1 cycle.
  - Sub-word stores: 2 cycles.
  - The memory write lands on the falling edge of the second cycle.
- `stall` is a Moore output of `IDLE` combined with request decode. It is high for exactly one cycle per sub-word store.
- **Back-to-back sub-word stores:** the next request enters `IDLE` on the cycle after `RMW_WR`. There are no bubbles beyond the one stall cycle.
- **Load after store to the same word:** correct with no forwarding. The falling-edge write completes before the next cycle's combinational read.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - `misaligned`=1 for half with `addr[0]`=1, or word with `addr[1:0]`!=0, while `req_valid`=1.
  - The access is then suppressed: `mem_read`=`mem_write`=0, `rdata`=0, `stall`=0, FSM stays in `IDLE`.
- Macro undefined: the port is absent and silent alignment applies.

## Structure
- Package `lsu_pkg` holds:
  - size encodings `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`;
  - state enum `IDLE`/`RMW_WR`;
  - the default `BADDR_W`.
- Sub-module `lsu_lane_mux` is purely combinational. It does lane extraction with sign/zero extension, and lane merge for stores.
- FSM and `merge_q` live in the top module.

## Test plan
- Memory word 5 = `0x8899AABB`; lb at byte addr 21 -> `rdata`=`0xFFFFFF99`, no stall. lbu at the same address -> `0x00000099`.
- lh at byte addr 22 -> `rdata`=`0xFFFFAABB`; lhu -> `0x0000AABB`.
- Word 5 = `0x8899AABB`; sb `0x12` at byte addr 20 -> `stall` for 1 cycle, `mem_read` then `mem_write`, word becomes `0x1299AABB`.
- Reset asserted in `RMW_WR` of an sh -> no `mem_write` pulse; word unchanged; state `IDLE`; all outputs 0.
- Two consecutive sb to addr 20 then 21 (`0x11`, `0x22`) on word 5 = `0` -> word 5 = `0x11220000`, total 4 cycles.
- With `LSU_MISALIGN_TRAP_EN`: lw at addr 6 -> `misaligned`=1, `mem_read`=0, `rdata`=0. Without the macro -> reads word 1.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: access sizes, RMW state, default address width.
package lsu_pkg;

  localparam int unsigned LSU_BADDR_W = 15;
  localparam int unsigned DATA_W      = 32;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } lsu_state_e;

  // Encodings 2 and 3 both mean a full word access.
  function automatic logic is_word(input logic [1:0] size);
    return size[1];
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core request and word-memory signals of the load/store unit.
// The misaligned flag exists only when LSU_MISALIGN_TRAP_EN is defined.
interface load_store_unit_if #(
  parameter int unsigned BADDR_W = lsu_pkg::LSU_BADDR_W
);

  logic                 req_valid;
  logic                 req_write;
  logic [1:0]           req_size;
  logic                 req_unsigned;
  logic [BADDR_W-1:0]   req_addr;
  logic [31:0]          req_wdata;
  logic                 stall;
  logic [31:0]          rdata;
`ifdef LSU_MISALIGN_TRAP_EN
  logic                 misaligned;
`endif
  logic [BADDR_W-3:0]   mem_addr;
  logic                 mem_read;
  logic                 mem_write;
  logic [31:0]          mem_wdata;
  logic [31:0]          mem_rdata;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
`ifdef LSU_MISALIGN_TRAP_EN
    output misaligned,
`endif
    output stall, rdata, mem_addr, mem_read, mem_write, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
`ifdef LSU_MISALIGN_TRAP_EN
    input  misaligned,
`endif
    input  stall, rdata, mem_addr, mem_read, mem_write, mem_wdata
  );

endinterface

// File: rtl/load_store_unit_lane_mux.sv
// Big-endian lane extraction with sign/zero extension for loads, and lane merge
// of right-aligned store data into a previously read word.
module lsu_lane_mux
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] merge_i,
  output logic [31:0] load_o,
  output logic [31:0] merged_o
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Offset 0 is the most significant lane, so the shift is (3 - offset) lanes.
  assign byte_sh = {~offset_i, 3'b000};
  assign half_sh = {~offset_i[1], 4'b0000};
  assign byte_v  = 8'(word_i >> byte_sh);
  assign half_v  = 16'(word_i >> half_sh);

  always_comb begin
    load_o   = word_i;
    merged_o = wdata_i;
    if (size_i == SZ_BYTE) begin
      load_o   = {{24{~unsigned_i & byte_v[7]}}, byte_v};
      merged_o = (merge_i & ~(32'h0000_00FF << byte_sh)) |
                 (32'(wdata_i[7:0]) << byte_sh);
    end else if (size_i == SZ_HALF) begin
      load_o   = {{16{~unsigned_i & half_v[15]}}, half_v};
      merged_o = (merge_i & ~(32'h0000_FFFF << half_sh)) |
                 (32'(wdata_i[15:0]) << half_sh);
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: sub-word loads by lane extract, sub-word stores by a two-cycle
// read-modify-write. Define LSU_MISALIGN_TRAP_EN to flag and suppress misaligned accesses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned BADDR_W = LSU_BADDR_W
) (
  input  logic                 clock,
  input  logic                 reset,
  load_store_unit_if.slave     bus
);

  lsu_state_e  state_q, state_d;
  logic [31:0] merge_q, merge_d;
  logic        trap;
  logic        go;
  logic        sub_store;
  logic [31:0] load_data;
  logic [31:0] merged;

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = bus.req_valid &
                (((bus.req_size == SZ_HALF) & bus.req_addr[0]) |
                 (is_word(bus.req_size) & (|bus.req_addr[1:0])));
  assign bus.misaligned = trap;
`else
  assign trap = 1'b0;
`endif

  assign go        = bus.req_valid & ~trap;
  assign sub_store = go & bus.req_write & ~is_word(bus.req_size);
  assign bus.mem_addr = bus.req_addr[BADDR_W-1:2];

  lsu_lane_mux u_lane_mux (
    .size_i     (bus.req_size),
    .unsigned_i (bus.req_unsigned),
    .offset_i   (bus.req_addr[1:0]),
    .word_i     (bus.mem_rdata),
    .wdata_i    (bus.req_wdata),
    .merge_i    (merge_q),
    .load_o     (load_data),
    .merged_o   (merged)
  );

  // Request decode and next state; memory controls are same-cycle.
  always_comb begin
    state_d       = state_q;
    merge_d       = merge_q;
    bus.stall     = 1'b0;
    bus.rdata     = '0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_wdata = '0;
    unique case (state_q)
      IDLE: begin
        if (go && !bus.req_write) begin
          bus.mem_read = 1'b1;
          bus.rdata    = load_data;
        end else if (go && is_word(bus.req_size)) begin
          bus.mem_write = 1'b1;
          bus.mem_wdata = bus.req_wdata;
        end else if (sub_store) begin
          bus.mem_read = 1'b1;
          bus.stall    = 1'b1;
          merge_d      = bus.mem_rdata;
          state_d      = RMW_WR;
        end
      end
      RMW_WR: begin
        // A dropped request here aborts the write.
        if (bus.req_valid) begin
          bus.mem_write = 1'b1;
          bus.mem_wdata = merged;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      merge_q <= '0;
    end else begin
      state_q <= state_d;
      merge_q <= merge_d;
    end
  end

endmodule
